xdff_pipe: RTL and testbench

Parametrised successor to the single-bit enable/set/reset flip-flop: a WIDTH-bit, DEPTH-stage registered delay line with per-stage valid tracking, global stall (enable), synchronous flush, synchronous preset and an occupancy counter. It sits between producer and consumer logic in the g5 datapath wherever a fixed-latency, stallable, flushable delay of multi-bit data is needed.

---
 rtl/xdff_pipe.sv | 89 ++++++++
 tb/tb_xdff_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/xdff_pipe.sv
// xdff_pipe: WIDTH-bit, DEPTH-stage registered delay line.
// Every stage carries a valid flag next to its data word. The whole line
// can stall (en=0), be flushed (clr), be preset (S) or be reset (Rs_n).
// An occupancy counter tracks how many stages currently hold valid data.
// All outputs come straight from flops, so no input reaches an output
// in the same cycle.
module xdff_pipe #(
    parameter int              WIDTH   = 8,
    parameter int              DEPTH   = 4,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
    input  logic                         clk0,
    input  logic                         Rs_n,
    input  logic [WIDTH-1:0]             D0,
    input  logic                         vin,
    input  logic                         en,
    input  logic                         clr,
    input  logic                         S,
    output logic [WIDTH-1:0]             Q0,
    output logic                         vout,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);

    localparam int CW = $clog2(DEPTH + 1);

    // Stage storage: index 0 is the entry stage, DEPTH-1 drives the outputs.
    logic [WIDTH-1:0] data_r  [DEPTH];
    logic [WIDTH-1:0] data_s  [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] valid_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;

    // Next-state selection: flush beats preset, preset beats advance, else hold.
    always_comb begin
        data_s  = data_r;
        valid_s = valid_r;
        cnt_s   = cnt_r;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_s[i] = {WIDTH{1'b0}};
            end
            valid_s = {DEPTH{1'b0}};
            cnt_s   = {CW{1'b0}};
        end else if (S) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_s[i] = SET_VAL;
            end
            valid_s = {DEPTH{1'b1}};
            cnt_s   = CW'(DEPTH);
        end else if (en) begin
            // Data shifts regardless of valid so idle stages stay deterministic.
            data_s[0]  = D0;
            valid_s[0] = vin;
            for (int i = 1; i < DEPTH; i++) begin
                data_s[i]  = data_r[i-1];
                valid_s[i] = valid_r[i-1];
            end
            // One entry in, one entry out; both at once leaves the count alone.
            cnt_s = cnt_r + CW'(vin) - CW'(valid_r[DEPTH-1]);
        end else begin
            data_s  = data_r;
            valid_s = valid_r;
            cnt_s   = cnt_r;
        end
    end

    // State registers with synchronous active-low reset taking top priority.
    always_ff @(posedge clk0) begin
        if (!Rs_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
            valid_r <= {DEPTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= data_s[i];
            end
            valid_r <= valid_s;
            cnt_r   <= cnt_s;
        end
    end

    assign Q0   = data_r[DEPTH-1];
    assign vout = valid_r[DEPTH-1];
    assign cnt  = cnt_r;

endmodule

// File: tb/tb_xdff_pipe.sv
// Self-checking bench for xdff_pipe: directed vector table for the
// WIDTH=8/DEPTH=4 instance, a hand sequence for a WIDTH=1/DEPTH=1
// instance, and random stimulus against a queue-based reference model.
module tb_xdff_pipe;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk0 = 1'b0;
    logic         rs_n, vin, en, clr, s;
    logic [W-1:0] d0;
    logic [W-1:0] q0;
    logic         vout;
    logic [2:0]   cnt;

    logic         rs_n1, vin1, en1, clr1, s1;
    logic [0:0]   d1;
    logic [0:0]   q1;
    logic         vout1;
    logic [0:0]   cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk0 = ~clk0;

    xdff_pipe #(.WIDTH(W), .DEPTH(D), .SET_VAL(8'hFF)) dut (
        .clk0(clk0), .Rs_n(rs_n), .D0(d0), .vin(vin), .en(en),
        .clr(clr), .S(s), .Q0(q0), .vout(vout), .cnt(cnt)
    );

    xdff_pipe #(.WIDTH(1), .DEPTH(1), .SET_VAL(1'b1)) dut1 (
        .clk0(clk0), .Rs_n(rs_n1), .D0(d1), .vin(vin1), .en(en1),
        .clr(clr1), .S(s1), .Q0(q1), .vout(vout1), .cnt(cnt1)
    );

    typedef struct {
        logic         rs_n, clr, s, en, vin;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic         v;
        logic [2:0]   c;
        string        name;
    } vec_t;

    vec_t vecs[$];

    typedef struct { logic v; logic [W-1:0] d; } ent_t;
    ent_t pipe[$];

    task automatic add(input logic r, input logic c_, input logic s_, input logic e,
                       input logic vi, input logic [W-1:0] dd,
                       input logic [W-1:0] qq, input logic vv, input logic [2:0] cc,
                       input string nm);
        vec_t x;
        x.rs_n = r; x.clr = c_; x.s = s_; x.en = e; x.vin = vi; x.d = dd;
        x.q = qq; x.v = vv; x.c = cc; x.name = nm;
        vecs.push_back(x);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: the pipe is a list of DEPTH (valid,data) entries.
    task automatic model_fill(input logic v, input logic [W-1:0] dd);
        ent_t e;
        e.v = v; e.d = dd;
        pipe.delete();
        for (int i = 0; i < D; i++) pipe.push_back(e);
    endtask

    function automatic int model_cnt();
        int n = 0;
        foreach (pipe[i]) if (pipe[i].v) n++;
        return n;
    endfunction

    task automatic step(input logic r, input logic c_, input logic s_, input logic e,
                        input logic vi, input logic [W-1:0] dd);
        ent_t x;
        @(negedge clk0);
        rs_n = r; clr = c_; s = s_; en = e; vin = vi; d0 = dd;
        @(posedge clk0);
        if (!r)       model_fill(1'b0, 8'h00);
        else if (c_)  model_fill(1'b0, 8'h00);
        else if (s_)  model_fill(1'b1, 8'hFF);
        else if (e) begin
            x.v = vi; x.d = dd;
            pipe.push_front(x);
            void'(pipe.pop_back());
        end
        #1;
    endtask

    task automatic step1(input logic r, input logic c_, input logic s_, input logic e,
                         input logic vi, input logic dd);
        @(negedge clk0);
        rs_n1 = r; clr1 = c_; s1 = s_; en1 = e; vin1 = vi; d1 = dd;
        @(posedge clk0);
        #1;
    endtask

    initial begin
        rs_n = 1'b0; clr = 1'b0; s = 1'b0; en = 1'b0; vin = 1'b0; d0 = 8'h00;
        rs_n1 = 1'b0; clr1 = 1'b0; s1 = 1'b0; en1 = 1'b0; vin1 = 1'b0; d1 = 1'b0;
        model_fill(1'b0, 8'h00);

        //   rs  clr s   en  vin d      q      v    cnt
        add(1'b0,1'b0,1'b1,1'b1,1'b1,8'hA5, 8'h00,1'b0,3'd0,"reset1");
        add(1'b0,1'b0,1'b1,1'b1,1'b1,8'hA5, 8'h00,1'b0,3'd0,"reset2");
        add(1'b1,1'b0,1'b0,1'b1,1'b1,8'h01, 8'h00,1'b0,3'd1,"fill1");
        add(1'b1,1'b0,1'b0,1'b1,1'b1,8'h02, 8'h00,1'b0,3'd2,"fill2");
        add(1'b1,1'b0,1'b0,1'b1,1'b1,8'h03, 8'h00,1'b0,3'd3,"fill3");
        add(1'b1,1'b0,1'b0,1'b1,1'b1,8'h04, 8'h01,1'b1,3'd4,"fill4");
        add(1'b1,1'b0,1'b0,1'b1,1'b1,8'h05, 8'h02,1'b1,3'd4,"fill5");
        add(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h03,1'b1,3'd3,"drain1");
        add(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h04,1'b1,3'd2,"drain2");
        add(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h05,1'b1,3'd1,"drain3");
        add(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h00,1'b0,3'd0,"drain4");
        add(1'b1,1'b0,1'b0,1'b1,1'b1,8'h11, 8'h00,1'b0,3'd1,"load11");
        add(1'b1,1'b0,1'b0,1'b1,1'b1,8'h22, 8'h00,1'b0,3'd2,"load22");
        add(1'b1,1'b0,1'b0,1'b0,1'b1,8'h33, 8'h00,1'b0,3'd2,"stall1");
        add(1'b1,1'b0,1'b0,1'b0,1'b0,8'h44, 8'h00,1'b0,3'd2,"stall2");
        add(1'b1,1'b0,1'b0,1'b0,1'b1,8'h55, 8'h00,1'b0,3'd2,"stall3");
        add(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h00,1'b0,3'd2,"resume1");
        add(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h11,1'b1,3'd2,"resume2");
        add(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h22,1'b1,3'd1,"resume3");
        add(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h00,1'b0,3'd0,"resume4");
        add(1'b1,1'b0,1'b0,1'b1,1'b1,8'hA1, 8'h00,1'b0,3'd1,"fl_load1");
        add(1'b1,1'b0,1'b0,1'b1,1'b1,8'hA2, 8'h00,1'b0,3'd2,"fl_load2");
        add(1'b1,1'b0,1'b0,1'b1,1'b1,8'hA3, 8'h00,1'b0,3'd3,"fl_load3");
        add(1'b1,1'b1,1'b0,1'b1,1'b1,8'hA4, 8'h00,1'b0,3'd0,"flush");
        add(1'b1,1'b0,1'b0,1'b1,1'b1,8'hB1, 8'h00,1'b0,3'd1,"fl_load4");
        add(1'b1,1'b0,1'b0,1'b1,1'b1,8'hB2, 8'h00,1'b0,3'd2,"fl_load5");
        add(1'b1,1'b1,1'b1,1'b1,1'b1,8'hB3, 8'h00,1'b0,3'd0,"clr_and_s");
        add(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00, 8'hFF,1'b1,3'd4,"preset");
        add(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'hFF,1'b1,3'd3,"pre_drain1");
        add(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'hFF,1'b1,3'd2,"pre_drain2");
        add(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'hFF,1'b1,3'd1,"pre_drain3");
        add(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h00,1'b0,3'd0,"pre_drain4");
        add(1'b1,1'b0,1'b1,1'b0,1'b0,8'h00, 8'hFF,1'b1,3'd4,"preset2");
        add(1'b0,1'b0,1'b0,1'b1,1'b1,8'h77, 8'h00,1'b0,3'd0,"reset_mid");

        foreach (vecs[i]) begin
            step(vecs[i].rs_n, vecs[i].clr, vecs[i].s, vecs[i].en, vecs[i].vin, vecs[i].d);
            chk({vecs[i].name, ".q"},   int'(q0),   int'(vecs[i].q));
            chk({vecs[i].name, ".v"},   int'(vout), int'(vecs[i].v));
            chk({vecs[i].name, ".cnt"}, int'(cnt),  int'(vecs[i].c));
        end

        // Single-stage, single-bit instance.
        step1(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("d1_reset.q", int'(q1), 0); chk("d1_reset.v", int'(vout1), 0);
        chk("d1_reset.cnt", int'(cnt1), 0);
        step1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("d1_in.q", int'(q1), 1); chk("d1_in.v", int'(vout1), 1);
        chk("d1_in.cnt", int'(cnt1), 1);
        step1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("d1_both.q", int'(q1), 0); chk("d1_both.v", int'(vout1), 1);
        chk("d1_both.cnt", int'(cnt1), 1);
        step1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("d1_stall.cnt", int'(cnt1), 1);
        step1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("d1_out.v", int'(vout1), 0); chk("d1_out.cnt", int'(cnt1), 0);
        step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("d1_set.q", int'(q1), 1); chk("d1_set.cnt", int'(cnt1), 1);
        step1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("d1_clr.q", int'(q1), 0); chk("d1_clr.cnt", int'(cnt1), 0);

        // Random stimulus against the queue model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom()),
                 8'($urandom()));
            chk("rnd.q",   int'(q0),   int'(pipe[D-1].d));
            chk("rnd.v",   int'(vout), int'(pipe[D-1].v));
            chk("rnd.cnt", int'(cnt),  model_cnt());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
